// File: rtl/data_cache_wb.sv
// Write-back, write-allocate data cache with round-robin replacement per set.
// One-word lines; a miss runs WRITEBACK (if dirty) -> REFILL_REQ -> REFILL_WAIT -> FILL,
// then the held CPU request hits in IDLE.
module data_cache_wb #(
    parameter int DATA_WIDTH        = 32,
    parameter int SET_ADDRESS_WIDTH = 2,
    parameter int WAYS              = 2,
    parameter int TAG_WIDTH         = DATA_WIDTH - SET_ADDRESS_WIDTH - 2
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] WD,
    input  logic [3:0]            BE,
    output logic [DATA_WIDTH-1:0] RD,
    output logic                  Stall,
    output logic                  MemReqValid,
    output logic                  MemReqWrite,
    output logic [DATA_WIDTH-1:0] MemAddr,
    output logic [DATA_WIDTH-1:0] MemWData,
    input  logic                  MemReqReady,
    input  logic                  MemRValid,
    input  logic [DATA_WIDTH-1:0] MemRData,
    output logic [15:0]           HitCount,
    output logic [15:0]           MissCount
);
    localparam int SETS  = 2 ** SET_ADDRESS_WIDTH;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [2:0] {IDLE, WRITEBACK, REFILL_REQ, REFILL_WAIT, FILL} state_t;
    state_t state, state_nxt;

    logic [WAYS-1:0]       valid_q [SETS];
    logic [WAYS-1:0]       dirty_q [SETS];
    logic [WAY_W-1:0]      ptr_q   [SETS];
    logic [TAG_WIDTH-1:0]  tag_q   [SETS][WAYS];
    logic [DATA_WIDTH-1:0] data_q  [SETS][WAYS];

    logic [WAY_W-1:0]      victim_q;
    logic [DATA_WIDTH-1:0] refill_q;
    logic [15:0]           hit_cnt, miss_cnt;

    logic [TAG_WIDTH-1:0]         a_tag;
    logic [SET_ADDRESS_WIDTH-1:0] a_set;
    logic                         req, is_wr, hit, do_hit, do_miss;
    logic [WAY_W-1:0]             hit_way, vic_way;
    logic                         unused_a;

    assign a_tag     = A[DATA_WIDTH-1:SET_ADDRESS_WIDTH+2];
    assign a_set     = A[SET_ADDRESS_WIDTH+1:2];
    assign unused_a  = ^A[1:0];
    // A simultaneous read+write is handled as a write.
    assign is_wr     = MemWrite;
    assign req       = MemRead | MemWrite;
    assign HitCount  = hit_cnt;
    assign MissCount = miss_cnt;

    function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] old,
                                                    input logic [DATA_WIDTH-1:0] wd,
                                                    input logic [3:0] be);
        merge = old;
        for (int i = 0; i < 4; i++)
            if (be[i]) merge[8*i +: 8] = wd[8*i +: 8];
    endfunction

    // Tag lookup and victim choice; descending scans make the lowest index win.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        vic_way = ptr_q[a_set];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[a_set][w] && tag_q[a_set][w] == a_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_q[a_set][w]) vic_way = WAY_W'(w);
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_nxt   = state;
        Stall       = 1'b0;
        RD          = '0;
        MemReqValid = 1'b0;
        MemReqWrite = 1'b0;
        MemAddr     = '0;
        MemWData    = '0;
        do_hit      = 1'b0;
        do_miss     = 1'b0;
        case (state)
            IDLE: if (req) begin
                if (hit) begin
                    do_hit = 1'b1;
                    if (!is_wr) RD = data_q[a_set][hit_way];
                end else begin
                    do_miss   = 1'b1;
                    Stall     = 1'b1;
                    state_nxt = (valid_q[a_set][vic_way] && dirty_q[a_set][vic_way])
                                ? WRITEBACK : REFILL_REQ;
                end
            end
            WRITEBACK: begin
                Stall       = 1'b1;
                MemReqValid = 1'b1;
                MemReqWrite = 1'b1;
                MemAddr     = {tag_q[a_set][victim_q], a_set, 2'b00};
                MemWData    = data_q[a_set][victim_q];
                if (MemReqReady) state_nxt = REFILL_REQ;
            end
            REFILL_REQ: begin
                Stall       = 1'b1;
                MemReqValid = 1'b1;
                MemAddr     = {a_tag, a_set, 2'b00};
                if (MemReqReady) state_nxt = REFILL_WAIT;
            end
            REFILL_WAIT: begin
                Stall = 1'b1;
                if (MemRValid) state_nxt = FILL;
            end
            FILL: begin
                Stall     = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Outputs read as idle while reset is held, even with a request pending.
        if (!RST_N) begin
            Stall = 1'b0;
            RD    = '0;
        end
    end

    // Control state: FSM, metadata bits, counters, refill capture.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            victim_q <= '0;
            refill_q <= '0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                ptr_q[s]   <= '0;
            end
        end else begin
            state <= state_nxt;
            if (do_hit && hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
            if (do_miss && miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
            if (do_miss) victim_q <= vic_way;
            if (state == REFILL_WAIT && MemRValid) refill_q <= MemRData;
            if (do_hit && is_wr) dirty_q[a_set][hit_way] <= 1'b1;
            if (state == FILL) begin
                valid_q[a_set][victim_q] <= 1'b1;
                dirty_q[a_set][victim_q] <= is_wr;
                if (victim_q == ptr_q[a_set])
                    ptr_q[a_set] <= (ptr_q[a_set] == WAY_W'(WAYS - 1)) ? '0 : ptr_q[a_set] + 1'b1;
            end
        end
    end

    // Tag/data arrays are not reset; only IDLE hits and FILL write them.
    always_ff @(posedge CLK) begin
        if (do_hit && is_wr)
            data_q[a_set][hit_way] <= merge(data_q[a_set][hit_way], WD, BE);
        if (state == FILL) begin
            tag_q[a_set][victim_q]  <= a_tag;
            data_q[a_set][victim_q] <= is_wr ? merge(refill_q, WD, BE) : refill_q;
        end
    end
endmodule

// File: tb/tb_data_cache_wb.sv
// Directed bench for data_cache_wb with a small latency-3 memory responder.
module tb_data_cache_wb;
    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        MemRead = 1'b0, MemWrite = 1'b0;
    logic [31:0] A = '0, WD = '0;
    logic [3:0]  BE = '0;
    logic [31:0] RD;
    logic        Stall, MemReqValid, MemReqWrite;
    logic [31:0] MemAddr, MemWData;
    logic        MemReqReady = 1'b1;
    logic        MemRValid;
    logic [31:0] MemRData;
    logic [15:0] HitCount, MissCount;

    localparam int STALL_CLEAN = 7;
    localparam int STALL_WB    = 8;
    localparam int LIMIT       = 200;

    int tests = 0, fails = 0;

    data_cache_wb dut (
        .CLK(CLK), .RST_N(RST_N), .MemRead(MemRead), .MemWrite(MemWrite),
        .A(A), .WD(WD), .BE(BE), .RD(RD), .Stall(Stall),
        .MemReqValid(MemReqValid), .MemReqWrite(MemReqWrite),
        .MemAddr(MemAddr), .MemWData(MemWData), .MemReqReady(MemReqReady),
        .MemRValid(MemRValid), .MemRData(MemRData),
        .HitCount(HitCount), .MissCount(MissCount)
    );

    always #5 CLK = ~CLK;

    // Backing memory contents and writeback log.
    logic [31:0] mem [logic [31:0]];
    logic [31:0] pend_addr, wb_addr, wb_data;
    int          lat, wb_cnt;

    function automatic logic [31:0] rd_mem(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    // Memory responder: refill data returns three edges after the request handshake.
    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            lat       <= 0;
            MemRValid <= 1'b0;
            MemRData  <= '0;
        end else begin
            MemRValid <= 1'b0;
            if (lat > 0) begin
                lat <= lat - 1;
                if (lat == 1) begin
                    MemRValid <= 1'b1;
                    MemRData  <= rd_mem(pend_addr);
                end
            end
            if (MemReqValid && MemReqReady) begin
                if (MemReqWrite) begin
                    wb_addr <= MemAddr;
                    wb_data <= MemWData;
                    wb_cnt  <= wb_cnt + 1;
                end else begin
                    lat       <= 3;
                    pend_addr <= MemAddr;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one access, wait out the stall, sample RD on the hit cycle.
    task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] be,
                          output logic [31:0] rdata, output int stalls);
        int n = 0;
        MemRead = rd; MemWrite = wr; A = addr; WD = wd; BE = be;
        #1;
        while (Stall && n < LIMIT) begin
            n++;
            @(negedge CLK); #1;
        end
        chk("no_timeout", n < LIMIT, 1);
        rdata = RD;
        stalls = n;
        @(posedge CLK);
        @(negedge CLK);
        MemRead = 1'b0; MemWrite = 1'b0;
    endtask

    logic [31:0] r;
    int          st, n;
    logic        ok;

    initial begin
        wb_cnt = 0;
        mem[32'h100] = 32'hDEADBEEF;
        mem[32'h200] = 32'h0BAD0200;
        mem[32'h300] = 32'h33333333;
        mem[32'h400] = 32'h44444444;
        mem[32'h500] = 32'h55555555;
        mem[32'h600] = 32'h12345678;

        // Reset state.
        repeat (2) @(negedge CLK);
        #1;
        chk("rst_stall", Stall, 0);
        chk("rst_reqv", MemReqValid, 0);
        chk("rst_addr", MemAddr, 0);
        chk("rst_rd", RD, 0);
        chk("rst_hits", HitCount, 0);
        chk("rst_miss", MissCount, 0);
        RST_N = 1'b1;
        @(negedge CLK); #1;
        chk("idle_rd", RD, 0);
        chk("idle_stall", Stall, 0);

        // Cold read miss then hit.
        access(1, 0, 32'h100, 0, 0, r, st);
        chk("cold_rd", r, 32'hDEADBEEF);
        chk("cold_stalls", st, STALL_CLEAN);
        chk("cold_miss", MissCount, 1);
        chk("cold_hit", HitCount, 1);

        // Partial write hit, then read back.
        access(0, 1, 32'h100, 32'h11223344, 4'b0011, r, st);
        chk("wrhit_stalls", st, 0);
        access(1, 0, 32'h100, 0, 0, r, st);
        chk("wrhit_rd", r, 32'hDEAD3344);

        // Fill way 1 of set 0 with a dirty line.
        access(0, 1, 32'h200, 32'hCAFEF00D, 4'hF, r, st);
        chk("wrmiss_stalls", st, STALL_CLEAN);

        // Set 0 full and dirty: evict the pointer way with memory not ready for 10 cycles.
        MemReqReady = 1'b0; MemRead = 1'b1; A = 32'h300;
        #1;
        chk("evict_stall", Stall, 1);
        @(negedge CLK); #1;
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (!(MemReqValid && MemReqWrite && MemAddr == 32'h100 && MemWData == 32'hDEAD3344))
                ok = 1'b0;
            @(negedge CLK); #1;
        end
        chk("wb_stable", ok, 1);
        MemReqReady = 1'b1;
        n = 0;
        while (Stall && n < LIMIT) begin
            n++;
            @(negedge CLK); #1;
        end
        chk("evict_no_timeout", n < LIMIT, 1);
        chk("evict_rd", RD, 32'h33333333);
        @(posedge CLK);
        @(negedge CLK);
        MemRead = 1'b0;
        chk("wb1_addr", wb_addr, 32'h100);
        chk("wb1_data", wb_data, 32'hDEAD3344);

        // Dirty 0x200 line must still be resident.
        access(1, 0, 32'h200, 0, 0, r, st);
        chk("keep_stalls", st, 0);
        chk("keep_rd", r, 32'hCAFEF00D);

        // Pointer toggled to way 1, so 0x200 is the next victim.
        access(1, 0, 32'h400, 0, 0, r, st);
        chk("wb2_stalls", st, STALL_WB);
        chk("wb2_addr", wb_addr, 32'h200);
        chk("wb2_data", wb_data, 32'hCAFEF00D);
        chk("wb2_cnt", wb_cnt, 2);
        chk("wb2_rd", r, 32'h44444444);
        chk("mid_hits", HitCount, 7);
        chk("mid_miss", MissCount, 4);

        // Write miss merges bytes into refill data; read+write together acts as write.
        access(0, 1, 32'h600, 32'hAABBCCDD, 4'b1100, r, st);
        chk("wmerge_stalls", st, STALL_CLEAN);
        access(1, 0, 32'h600, 0, 0, r, st);
        chk("wmerge_rd", r, 32'hAABB5678);
        access(1, 1, 32'h600, 32'h000000EE, 4'b0001, r, st);
        access(1, 0, 32'h600, 0, 0, r, st);
        chk("rw_rd", r, 32'hAABB56EE);
        chk("rw_hits", HitCount, 11);
        chk("rw_miss", MissCount, 5);

        // Reset while in REFILL_WAIT.
        MemRead = 1'b1; A = 32'h500;
        @(negedge CLK);
        @(negedge CLK); #1;
        chk("wait_stall", Stall, 1);
        chk("wait_reqv", MemReqValid, 0);
        RST_N = 1'b0;
        #1;
        chk("abort_stall", Stall, 0);
        chk("abort_reqv", MemReqValid, 0);
        chk("abort_rd", RD, 0);
        chk("abort_hits", HitCount, 0);
        chk("abort_miss", MissCount, 0);
        MemRead = 1'b0;
        @(negedge CLK); #1;
        RST_N = 1'b1;
        access(1, 0, 32'h500, 0, 0, r, st);
        chk("post_rst_stalls", st, STALL_CLEAN);
        chk("post_rst_rd", r, 32'h55555555);
        chk("post_rst_miss", MissCount, 1);

        // Miss counter saturation.
        dut.miss_cnt = 16'hFFFE;
        access(1, 0, 32'h1004, 0, 0, r, st);
        chk("sat1", MissCount, 16'hFFFF);
        access(1, 0, 32'h2004, 0, 0, r, st);
        access(1, 0, 32'h3004, 0, 0, r, st);
        chk("sat3_stalls", st, STALL_CLEAN);
        chk("sat3", MissCount, 16'hFFFF);
        chk("sat_hits", HitCount, 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule

// File: doc/data_cache_wb.md
DATA_CACHE_WB -- requirements
Module: data_cache_wb

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  - DATA_WIDTH, 32, word and address width.
  - SET_ADDRESS_WIDTH, 2, log2(sets); sets = 2**SET_ADDRESS_WIDTH.
  - WAYS, 2, associativity; legal values 1, 2, 4.
  - TAG_WIDTH, DATA_WIDTH-SET_ADDRESS_WIDTH-2, tag bits.
REQ-002 Ports (name, direction, width, meaning), one per line:
  - CLK, in, 1, the single clock; all state changes on the rising edge.
  - RST_N, in, 1, asynchronous active-low reset.
  - MemRead, in, 1, CPU load request.
  - MemWrite, in, 1, CPU store request.
  - A, in, DATA_WIDTH, byte address; word-aligned, bits [1:0] ignored.
  - WD, in, DATA_WIDTH, store data.
  - BE, in, 4, store byte enables (bit i covers WD[8i+7:8i]).
  - RD, out, DATA_WIDTH, load data.
  - Stall, out, 1, CPU must hold request and inputs stable.
  - MemReqValid, out, 1, memory request valid.
  - MemReqWrite, out, 1, 1 = writeback, 0 = refill read.
  - MemAddr, out, DATA_WIDTH, word-aligned memory address.
  - MemWData, out, DATA_WIDTH, writeback data.
  - MemReqReady, in, 1, memory accepts request.
  - MemRValid, in, 1, refill data valid.
  - MemRData, in, DATA_WIDTH, refill data.
  - HitCount, out, 16, saturating hit counter.
  - MissCount, out, 16, saturating miss counter.
REQ-003 The clock is CLK; reset is RST_N, asynchronous and active-low; there is exactly one clock.

Function
REQ-004 Address split: tag = A[DATA_WIDTH-1:SET_ADDRESS_WIDTH+2]; set = A[SET_ADDRESS_WIDTH+1:2].
REQ-005 Each way of each set holds valid, dirty, tag and one data word; each set holds a round-robin victim pointer (log2(WAYS) bits).
REQ-006 MemRead and MemWrite asserted together: the cycle is treated as a write.
REQ-007 FSM states: IDLE, WRITEBACK, REFILL_REQ, REFILL_WAIT, FILL.
REQ-008 IDLE lookup is combinational. A hit is valid with a matching tag in any way; if more than one way matches, the lowest index wins.
REQ-009 Read hit: RD = the hit way's word in the same cycle, Stall = 0, HitCount += 1.
REQ-010 Write hit: bytes selected by BE are merged into the hit way at the edge and dirty is set; Stall = 0; HitCount += 1.
REQ-011 Miss in IDLE:
  - Stall = 1 combinationally; MissCount += 1 once per miss.
  - Victim is the lowest-index invalid way; if all ways are valid, the victim is the set pointer way.
  - Next state is WRITEBACK if the victim is valid and dirty, otherwise REFILL_REQ.
REQ-012 WRITEBACK:
  - MemReqValid = 1, MemReqWrite = 1, MemAddr = {victim tag, set, 2'b00}, MemWData = victim word.
  - Held stable until MemReqReady = 1, then go to REFILL_REQ.
REQ-013 REFILL_REQ: MemReqValid = 1, MemReqWrite = 0, MemAddr = {tag, set, 2'b00}; held until MemReqReady = 1, then go to REFILL_WAIT.
REQ-014 REFILL_WAIT: capture MemRData when MemRValid = 1, then go to FILL. MemRValid in any other state is ignored.
REQ-015 FILL:
  - Victim gets valid = 1, the new tag, the refill word with BE-selected WD bytes merged if the access is a write, and dirty = MemWrite.
  - Set pointer advances modulo WAYS only if the victim was the pointer way.
  - Go to IDLE. Stall stays 1 in FILL.
REQ-016 After FILL the held request hits in IDLE; HitCount increments for that access.
REQ-017 Stall = 1 in every non-IDLE state. MemReqValid = 0 outside WRITEBACK and REFILL_REQ.
REQ-018 With no request in IDLE: no state change, RD = 0, Stall = 0.
REQ-019 Counters saturate at 16'hFFFF and do not wrap.
REQ-020 MemReqReady and MemRValid asserted in the same cycle: only the current state's handshake is honoured; no state is skipped.

Reset
REQ-021 RST_N = 0 asynchronously sets:
  - FSM = IDLE;
  - all valid, dirty and pointer bits = 0;
  - Stall = 0, MemReqValid = 0, MemReqWrite = 0, MemAddr = 0, MemWData = 0, RD = 0;
  - HitCount = 0, MissCount = 0.
  Data and tag arrays need not be cleared.
REQ-022 Reset mid-transaction (any non-IDLE state) aborts with no array update. The memory side must tolerate the dropped request.
REQ-023 Deassertion of RST_N takes effect at the next rising CLK edge; the first request is accepted in that cycle.

Verification
REQ-024 Cold read A=0x100, memory returns 0xDEADBEEF after 3 cycles -> Stall high through FILL, RD=0xDEADBEEF, MissCount=1, HitCount=1.
REQ-025 Write A=0x100, WD=0x11223344, BE=4'b0011 after REQ-024 -> no stall; a following read gives RD=0xDEAD3344.
REQ-026 WAYS=2: fill dirty set 0 with tags T0 and T1, then access tag T2 -> WRITEBACK of the pointer way's address/data, then refill. Pointer toggles.
REQ-027 MemReqReady held low 10 cycles in WRITEBACK -> MemAddr, MemWData and MemReqValid stable throughout.
REQ-028 RST_N pulsed low during REFILL_WAIT -> all outputs at reset values immediately; a subsequent read of the same address misses.
REQ-029 Preload MissCount to 16'hFFFE via 3 misses -> counter stops at 16'hFFFF.
